// File: rtl/muldiv_sched_pkg.sv
// muldiv_sched_pkg: shared definitions for the multiply/divide scheduler.
//   - op bit indices of the one-hot request op field and its width
//   - scheduler state encodings
//   - iteration count of the multi-cycle engines
//   - md_decode(): picks one operation from a possibly multi-hot op field
package muldiv_sched_pkg;

  localparam int MD_OP_MULT  = 0;
  localparam int MD_OP_MULTU = 1;
  localparam int MD_OP_DIV   = 2;
  localparam int MD_OP_DIVU  = 3;
  localparam int MD_OP_WIDTH = 4;
  localparam int MD_ITER     = 32;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'd0,
    MD_S_MUL  = 2'd1,
    MD_S_DIV  = 2'd2,
    MD_S_DONE = 2'd3
  } md_state_e;

  typedef enum logic [1:0] {
    MD_K_MULT,
    MD_K_MULTU,
    MD_K_DIV,
    MD_K_DIVU
  } md_kind_e;

  // Multi-hot ops resolve as mult > multu > div > divu.
  function automatic md_kind_e md_decode(input logic [MD_OP_WIDTH-1:0] op);
    if (op[MD_OP_MULT])       return MD_K_MULT;
    else if (op[MD_OP_MULTU]) return MD_K_MULTU;
    else if (op[MD_OP_DIV])   return MD_K_DIV;
    else                      return MD_K_DIVU;
  endfunction

endpackage

// File: rtl/muldiv_sched_div_iter.sv
// div_iter: restoring unsigned division engine, one quotient bit per clock.
// Ports:
//   clk, reset          clock, async active-high reset
//   i_start             load operands and begin ITER steps (next edge)
//   i_clear             abandon the running division
//   i_dividend/divisor  unsigned magnitudes, sampled on i_start
//   o_quo/o_rem         values after the step taken on the current edge;
//                       final quotient/remainder when o_done is high
//   o_done              the coming edge performs the last step
module div_iter
  import muldiv_sched_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_clear,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem,
  output logic        o_done
);

  localparam int CNT_W = $clog2(ITER);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [31:0]      r_rem;
  logic [31:0]      r_quo;
  logic [31:0]      r_dvsr;

  logic [32:0]      w_shift;
  logic             w_fit;

  // Dividend bits shift out of the top of r_quo while quotient bits shift in.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fit   = (w_shift >= {1'b0, r_dvsr});
  // When the divisor fits, the difference is below the divisor, so 32 bits suffice.
  assign o_rem   = w_fit ? (w_shift[31:0] - r_dvsr) : w_shift[31:0];
  assign o_quo   = {r_quo[30:0], w_fit};
  assign o_done  = r_run & (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
    end else if (i_clear) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvsr <= i_divisor;
      r_cnt  <= CNT_W'(ITER - 1);
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_rem <= o_rem;
      r_quo <= o_quo;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: arbitrates pipe 0 / pipe 1 for the shared multiply/divide
// unit and runs one MULT/MULTU/DIV/DIVU at a time, returning {hi,lo}.
// Ports:
//   clk, reset                 clock, async active-high reset
//   reqN_valid/op/src1/src2    pipe N request (op one-hot: mult,multu,div,divu)
//   reqN_ready                 pipe N request accepted this cycle
//   flush                      drop the in-flight op and any pending result
//   res_valid/owner/hilo       result, owning pipe, {hi,lo}
//   res_ready                  consumer takes the result
//   busy                       scheduler not idle
// Build option: MUL_SINGLE_CYCLE_EN computes MULT/MULTU combinationally at
// accept and goes straight to DONE; otherwise a 32-step shift-add is used.
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens only here
// MUL   | shift-add multiply, one partial product per clock
// DIV   | restoring divide in div_iter, or one-cycle divide-by-zero result
// DONE  | result held on res_* until res_valid & res_ready
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [MD_OP_WIDTH-1:0] req0_op,
  input  logic [31:0]            req0_src1,
  input  logic [31:0]            req0_src2,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [MD_OP_WIDTH-1:0] req1_op,
  input  logic [31:0]            req1_src1,
  input  logic [31:0]            req1_src2,
  output logic                   req1_ready,
  input  logic                   flush,
  output logic                   res_valid,
  output logic                   res_owner,
  output logic [63:0]            res_hilo,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(ITER);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_prod;
  logic [31:0]      r_mcand;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dz;
  logic [31:0]      r_dz_hi;

  logic                   w_eff0;
  logic                   w_eff1;
  logic                   w_accept;
  logic [MD_OP_WIDTH-1:0] w_op;
  logic [31:0]            w_src1;
  logic [31:0]            w_src2;
  md_kind_e               w_kind;
  logic                   w_is_mul;
  logic                   w_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [31:0]            w_mag_a;
  logic [31:0]            w_mag_b;
  logic [32:0]            w_mul_add;
  logic [63:0]            w_mul_step;
  logic                   w_div_start;
  logic                   w_div_done;
  logic [31:0]            w_quo;
  logic [31:0]            w_rem;

  assign w_eff0     = req0_valid & (|req0_op);
  assign w_eff1     = req1_valid & (|req1_op);
  // Pipe 0 holds the older instruction, so it wins a tie.
  assign req0_ready = (r_state == MD_S_IDLE) & ~flush & ~reset & w_eff0;
  assign req1_ready = (r_state == MD_S_IDLE) & ~flush & ~reset & ~w_eff0 & w_eff1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_op     = w_eff0 ? req0_op   : req1_op;
  assign w_src1   = w_eff0 ? req0_src1 : req1_src1;
  assign w_src2   = w_eff0 ? req0_src2 : req1_src2;
  assign w_kind   = md_decode(w_op);
  assign w_is_mul = (w_kind == MD_K_MULT) | (w_kind == MD_K_MULTU);
  assign w_signed = (w_kind == MD_K_MULT) | (w_kind == MD_K_DIV);
  assign w_a_neg  = w_signed & w_src1[31];
  assign w_b_neg  = w_signed & w_src2[31];
  assign w_mag_a  = w_a_neg ? -w_src1 : w_src1;
  assign w_mag_b  = w_b_neg ? -w_src2 : w_src2;

  // r_prod holds {partial sum, remaining multiplier}; each step conditionally
  // adds the multiplicand to the upper half and shifts the whole thing right.
  assign w_mul_add  = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_mcand : 32'd0)};
  assign w_mul_step = {w_mul_add, r_prod[31:1]};

`ifdef MUL_SINGLE_CYCLE_EN
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_fast_prod;
  assign w_ext_a     = w_signed ? {{32{w_src1[31]}}, w_src1} : {32'd0, w_src1};
  assign w_ext_b     = w_signed ? {{32{w_src2[31]}}, w_src2} : {32'd0, w_src2};
  assign w_fast_prod = w_ext_a * w_ext_b;
`endif

  // A zero divisor never starts the engine; the DIV state emits the fixed result.
  assign w_div_start = w_accept & ~w_is_mul & (w_src2 != 32'd0);

  div_iter #(.ITER(ITER)) u_div_iter (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_clear    (flush),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_done     (w_div_done)
  );

  assign busy = (r_state != MD_S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MD_S_IDLE;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_hi   <= '0;
      res_valid <= 1'b0;
      res_owner <= 1'b0;
      res_hilo  <= '0;
    end else if (flush) begin
      r_state   <= MD_S_IDLE;
      res_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_S_IDLE: begin
          if (w_accept) begin
            res_owner <= ~w_eff0;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz_hi   <= w_src1;
            r_dz      <= (w_src2 == 32'd0);
            if (w_is_mul) begin
`ifdef MUL_SINGLE_CYCLE_EN
              res_hilo  <= w_fast_prod;
              res_valid <= 1'b1;
              r_state   <= MD_S_DONE;
`else
              r_mcand <= w_mag_a;
              r_prod  <= {32'd0, w_mag_b};
              r_cnt   <= CNT_W'(ITER - 1);
              r_state <= MD_S_MUL;
`endif
            end else begin
              r_state <= MD_S_DIV;
            end
          end
        end
        MD_S_MUL: begin
          r_prod <= w_mul_step;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            res_hilo  <= r_neg_res ? -w_mul_step : w_mul_step;
            res_valid <= 1'b1;
            r_state   <= MD_S_DONE;
          end
        end
        MD_S_DIV: begin
          if (r_dz) begin
            res_hilo  <= {r_dz_hi, 32'hFFFF_FFFF};
            res_valid <= 1'b1;
            r_state   <= MD_S_DONE;
          end else if (w_div_done) begin
            // HI = remainder with the dividend's sign, LO = signed quotient.
            res_hilo  <= {(r_neg_rem ? -w_rem : w_rem), (r_neg_res ? -w_quo : w_quo)};
            res_valid <= 1'b1;
            r_state   <= MD_S_DONE;
          end
        end
        MD_S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= MD_S_IDLE;
          end
        end
        default: r_state <= MD_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: accepted requests push the expected
// result into a queue; an independent monitor pops and compares whenever
// the DUT presents a result.
module tb_muldiv_sched;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        req0_ready, req1_ready;
  logic        flush;
  logic        res_valid, res_owner;
  logic [63:0] res_hilo;
  logic        res_ready = 1'b0;
  logic        busy;

  muldiv_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_src1  (req0_src1),
    .req0_src2  (req0_src2),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_src1  (req1_src1),
    .req1_src2  (req1_src2),
    .req1_ready (req1_ready),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_owner  (res_owner),
    .res_hilo   (res_hilo),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [63:0] hilo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          rr_mode = 0;
  bit          seen_first = 1'b0;
  logic [64:0] snap;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, SV division truncates toward zero.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    if (op[0]) return sa * sbv;
    if (op[1]) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[2]) begin
      q = sa / sbv;
      r = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Edges from the accept edge to the edge that registers the result.
  function automatic int lat(input logic [3:0] op, input logic [31:0] b);
    if (op[0] || op[1]) begin
`ifdef MUL_SINGLE_CYCLE_EN
      return 0;
`else
      return 32;
`endif
    end
    return (b == 32'd0) ? 1 : 32;
  endfunction

  always @(negedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  // Monitor
  always @(negedge clk) begin
    #3;
    if (!reset && res_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", res_valid, 0);
      end else begin
        if (!seen_first) begin
          seen_first = 1'b1;
          snap = {res_owner, res_hilo};
          chk("latency", 65'(cyc - sb[0].acc), 65'(sb[0].lat));
        end else begin
          chk("hold_stable", {res_owner, res_hilo}, snap);
        end
        if (res_ready) begin
          chk("owner", res_owner, sb[0].owner);
          chk("hilo", res_hilo, sb[0].hilo);
          void'(sb.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit v0, input logic [3:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [3:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       output int acc0, output int acc1);
    bit p0, p1;
    int guard;
    p0 = v0; p1 = v1; guard = 0; acc0 = -1; acc1 = -1;
    req0_op = o0; req0_src1 = a0; req0_src2 = b0;
    req1_op = o1; req1_src1 = a1; req1_src2 = b1;
    while ((p0 || p1) && guard < 300) begin
      @(negedge clk);
      #1;
      req0_valid = p0;
      req1_valid = p1;
      #1;
      if (req0_ready || req1_ready) begin
        if (p0 && p1) chk("arb_pipe0_first", {req0_ready, req1_ready}, 2'b10);
        else          chk("ready_exclusive", req0_ready & req1_ready, 0);
        if (req0_ready) begin
          sb.push_back('{owner: 1'b0, hilo: model(o0, a0, b0), lat: lat(o0, b0), acc: cyc + 1});
          acc0 = cyc + 1;
          p0 = 1'b0;
        end else begin
          sb.push_back('{owner: 1'b1, hilo: model(o1, a1, b1), lat: lat(o1, b1), acc: cyc + 1});
          acc1 = cyc + 1;
          p1 = 1'b0;
        end
      end
      guard++;
    end
    if (p0 || p1) begin
      checks++; failures++;
      $display("FAIL accept_timeout pending0=%0d pending1=%0d", p0, p1);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout outstanding=%0d required=0", sb.size());
      sb.delete();
      seen_first = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, acc_flush;
    logic [3:0] op0, op1;
    bit v0, v1;

    reset = 1'b1; flush = 1'b0;
    req0_valid = 1'b1; req0_op = OP_MULT; req0_src1 = 32'd1; req0_src2 = 32'd1;
    req1_valid = 1'b1; req1_op = OP_DIVU; req1_src1 = 32'd1; req1_src2 = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_owner", res_owner, 0);
    chk("rst_res_hilo", res_hilo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // -2 * 3 from pipe 0
    drive(1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, OP_MULT, 0, 0, a0, a1);
    wait_drain();

    // Simultaneous requests: pipe 0 DIVU served first, pipe 1 right after handshake
    drive(1, OP_DIVU, 32'd100, 32'd7, 1, OP_MULTU, 32'd2, 32'd2, a0, a1);
    wait_drain();
    chk("b2b_accept_edge", 65'(a1), 65'(a0 + lat(OP_DIVU, 32'd7) + 2));

    // Signed division corner cases and divide by zero
    drive(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, OP_MULT, 0, 0, a0, a1);
    drive(0, OP_MULT, 0, 0, 1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, a0, a1);
    drive(1, OP_DIVU, 32'd5, 32'd0, 0, OP_MULT, 0, 0, a0, a1);
    drive(1, OP_DIV, 32'hFFFF_FF00, 32'd0, 0, OP_MULT, 0, 0, a0, a1);
    wait_drain();

    // Flush at E10 of a DIV
    drive(1, OP_DIV, 32'd1000, 32'd3, 0, OP_MULT, 0, 0, acc_flush, a1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_res_valid", res_valid, 0);
    sb.delete();
    seen_first = 1'b0;
    drive(1, OP_MULTU, 32'd6, 32'd7, 0, OP_MULT, 0, 0, a0, a1);
    chk("flush_next_accept", 65'(a0), 65'(acc_flush + 11));
    wait_drain();

    // Consumer stalls: result must stay put
    rr_mode = 2;
    drive(0, OP_MULT, 0, 0, 1, OP_MULT, 32'h0001_2345, 32'hFFFF_0000, a0, a1);
    for (int k = 0; k < 100 && !res_valid; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("done_held", res_valid, 1);
    rr_mode = 0;
    wait_drain();

    // Async reset mid-DIV from pipe 1
    drive(0, OP_MULT, 0, 0, 1, OP_DIV, 32'hFFFF_0000, 32'h13, a0, a1);
    repeat (12) @(posedge clk);
    #1;
    chk("busy_mid_div", busy, 1);
    req1_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_owner", res_owner, 0);
    chk("arst_res_hilo", res_hilo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready1", req1_ready, 0);
    sb.delete();
    seen_first = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, OP_MULT, 0, 0, a0, a1);
    wait_drain();

    // Randomized traffic with random consumer back-pressure
    rr_mode = 1;
    for (int n = 0; n < 30; n++) begin
      op0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
      op1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       begin v0 = 1'b1; v1 = 1'b0; end
        1:       begin v0 = 1'b0; v1 = 1'b1; end
        default: begin v0 = 1'b1; v1 = 1'b1; end
      endcase
      drive(v0, op0, rnd_operand(), rnd_operand(), v1, op1, rnd_operand(), rnd_operand(), a0, a1);
    end
    wait_drain();
    rr_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
